// File: rtl/apb_master.sv
// APB requester: converts a valid/ready command into one SETUP + ACCESS transfer
// and reports completion on a one-cycle response strobe.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              _PCLK,
    input  logic              _PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              _PSEL1,
    output logic              _PENABLE,
    output logic              _PWRITE,
    output logic [ADDR_W-1:0] _PADDR,
    output logic [DATA_W-1:0] _PWDATA,
    input  logic [DATA_W-1:0] _PRDATA,
    input  logic              _PREADY,
    input  logic              _PSLVERR
);

    // TIMEOUT=0 disables the abort; keep a 1-bit counter so widths stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            _PSEL1      <= 1'b0;
            _PENABLE    <= 1'b0;
            _PWRITE     <= 1'b0;
            _PADDR      <= '0;
            _PWDATA     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        _PADDR  <= cmd_addr;
                        _PWRITE <= cmd_write;
                        _PWDATA <= cmd_write ? cmd_wdata : '0;
                        _PSEL1  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    _PENABLE <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (_PREADY) begin
                        _PSEL1      <= 1'b0;
                        _PENABLE    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= _PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= _PWRITE ? '0 : _PRDATA;
                        state       <= IDLE;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        _PSEL1      <= 1'b0;
                        _PENABLE    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a behavioural APB completer (memory,
// programmable wait states, error injection) and hand-computed expectations.
module tb_apb_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              _PCLK = 1'b0;
    logic              _PRESETn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              _PSEL1;
    logic              _PENABLE;
    logic              _PWRITE;
    logic [ADDR_W-1:0] _PADDR;
    logic [DATA_W-1:0] _PWDATA;
    logic [DATA_W-1:0] _PRDATA;
    logic              _PREADY;
    logic              _PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    // completer model controls
    logic        ready_en = 1'b1;
    int          wait_n   = 0;
    int          slv_mode = 0;   // 0: no error, 1: error always, 2: error only while not ready
    int          acc_cnt;
    logic [DATA_W-1:0] mem [256];

    always #5 _PCLK = ~_PCLK;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        ._PCLK(_PCLK), ._PRESETn(_PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        ._PSEL1(_PSEL1), ._PENABLE(_PENABLE), ._PWRITE(_PWRITE),
        ._PADDR(_PADDR), ._PWDATA(_PWDATA), ._PRDATA(_PRDATA),
        ._PREADY(_PREADY), ._PSLVERR(_PSLVERR)
    );

    assign _PREADY  = ready_en && (acc_cnt >= wait_n);
    assign _PRDATA  = mem[_PADDR];
    assign _PSLVERR = (slv_mode == 1) ? 1'b1 : (slv_mode == 2) ? !_PREADY : 1'b0;

    always @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) acc_cnt <= 0;
        else if (_PSEL1 && _PENABLE && !_PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge _PCLK) begin
        if (_PSEL1 && _PENABLE && _PREADY && _PWRITE) mem[_PADDR] <= _PWDATA;
    end

    // Present a command while IDLE, return #1 after the accepting edge.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge _PCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if ({_PSEL1, _PENABLE, _PWRITE} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {_PSEL1, _PENABLE, _PWRITE}); end
        n_cmp++; if ({_PADDR, _PWDATA} !== '0) begin n_bad++; $display("FAIL reset_bus: got %h/%h want 0/0", _PADDR, _PWDATA); end
        n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin n_bad++; $display("FAIL reset_rsp: got v%b e%b t%b d%h want all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        repeat (2) @(posedge _PCLK);
        #1 _PRESETn = 1'b1;
        @(posedge _PCLK);
        #1;
    endtask

    task automatic test_write;
        int psel_n, pen_n, rsp_at, pulses;
        logic rdy_at_rsp, err_at_rsp;
        wait_n = 0; slv_mode = 0; ready_en = 1'b1;
        issue(1'b1, 8'h10, 32'h0000_00A5);
        n_cmp++; if ({_PSEL1, _PENABLE, _PWRITE, cmd_ready} !== 4'b1010) begin n_bad++; $display("FAIL wr_setup_ctrl: got %b want 1010", {_PSEL1, _PENABLE, _PWRITE, cmd_ready}); end
        n_cmp++; if (_PADDR !== 8'h10 || _PWDATA !== 32'hA5) begin n_bad++; $display("FAIL wr_setup_bus: got %h/%h want 10/a5", _PADDR, _PWDATA); end
        psel_n = 1; pen_n = 0; rsp_at = -1; pulses = 0; rdy_at_rsp = 1'b0; err_at_rsp = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge _PCLK); #1;
            if (_PSEL1) psel_n++;
            if (_PENABLE) pen_n++;
            if (rsp_valid) begin
                pulses++;
                if (rsp_at < 0) begin rsp_at = k; rdy_at_rsp = cmd_ready; err_at_rsp = rsp_err; end
            end
        end
        n_cmp++; if (psel_n !== 2) begin n_bad++; $display("FAIL wr_psel_cycles: got %0d want 2", psel_n); end
        n_cmp++; if (pen_n !== 1) begin n_bad++; $display("FAIL wr_penable_cycles: got %0d want 1", pen_n); end
        n_cmp++; if (rsp_at !== 2 || pulses !== 1) begin n_bad++; $display("FAIL wr_rsp_timing: got edge %0d pulses %0d want edge 2 pulses 1", rsp_at, pulses); end
        n_cmp++; if (rdy_at_rsp !== 1'b1 || err_at_rsp !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_flags: got ready %b err %b want 1 0", rdy_at_rsp, err_at_rsp); end
        n_cmp++; if (_PADDR !== 8'h10 || _PWRITE !== 1'b1 || _PWDATA !== 32'hA5) begin n_bad++; $display("FAIL wr_idle_hold: got %h/%b/%h want 10/1/a5", _PADDR, _PWRITE, _PWDATA); end
    endtask

    task automatic test_read;
        int bad_dir, pulses;
        logic [DATA_W-1:0] rd;
        wait_n = 0; slv_mode = 0; ready_en = 1'b1;
        issue(1'b0, 8'h10, 32'h1234_5678);
        bad_dir = 0; pulses = 0; rd = '0;
        if (_PWRITE !== 1'b0 || _PWDATA !== '0) bad_dir++;
        for (int k = 1; k <= 4; k++) begin
            @(posedge _PCLK); #1;
            if (_PSEL1 && (_PWRITE !== 1'b0 || _PWDATA !== '0)) bad_dir++;
            if (rsp_valid) begin pulses++; rd = rsp_rdata; end
        end
        n_cmp++; if (bad_dir !== 0) begin n_bad++; $display("FAIL rd_dir_wdata: got %0d bad cycles want 0", bad_dir); end
        n_cmp++; if (pulses !== 1 || rd !== 32'hA5) begin n_bad++; $display("FAIL rd_data: got %h (%0d pulses) want a5 (1 pulse)", rd, pulses); end
        n_cmp++; if (rsp_rdata !== 32'hA5 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_hold: got %h err %b want a5 err 0", rsp_rdata, rsp_err); end
    endtask

    task automatic test_wait_states;
        int pen_n, pulses, unstable;
        logic [DATA_W-1:0] rd;
        logic err;
        wait_n = 3; slv_mode = 2; ready_en = 1'b1;
        issue(1'b0, 8'h10, 32'h0);
        pen_n = 0; pulses = 0; unstable = 0; rd = '0; err = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge _PCLK); #1;
            if (_PENABLE) begin
                pen_n++;
                if (_PSEL1 !== 1'b1 || _PADDR !== 8'h10 || _PWRITE !== 1'b0) unstable++;
            end
            if (rsp_valid) begin pulses++; rd = rsp_rdata; err = rsp_err; end
        end
        n_cmp++; if (pen_n !== 4) begin n_bad++; $display("FAIL ws_access_cycles: got %0d want 4", pen_n); end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL ws_bus_stable: got %0d unstable cycles want 0", unstable); end
        n_cmp++; if (pulses !== 1 || rd !== 32'hA5) begin n_bad++; $display("FAIL ws_rsp: got %h (%0d pulses) want a5 (1 pulse)", rd, pulses); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ws_err_ignored: got %b want 0", err); end
        wait_n = 0; slv_mode = 0;
    endtask

    task automatic test_slverr;
        int pulses;
        logic err, tmo;
        wait_n = 0; slv_mode = 1; ready_en = 1'b1;
        issue(1'b1, 8'h20, 32'h0000_005A);
        pulses = 0; err = 1'b0; tmo = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge _PCLK); #1;
            if (rsp_valid) begin pulses++; err = rsp_err; tmo = rsp_timeout; end
        end
        n_cmp++; if (pulses !== 1 || err !== 1'b1 || tmo !== 1'b0) begin n_bad++; $display("FAIL err_rsp: got pulses %0d err %b tmo %b want 1 1 0", pulses, err, tmo); end
        slv_mode = 0;
        issue(1'b1, 8'h21, 32'h0000_0077);
        n_cmp++; if (_PSEL1 !== 1'b1 || _PADDR !== 8'h21) begin n_bad++; $display("FAIL err_next_accept: got sel %b addr %h want 1 21", _PSEL1, _PADDR); end
        pulses = 0; err = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge _PCLK); #1;
            if (rsp_valid) begin pulses++; err = rsp_err; end
        end
        n_cmp++; if (pulses !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL err_next_rsp: got pulses %0d err %b want 1 0", pulses, err); end
    endtask

    task automatic test_timeout;
        int pen_n, pulses;
        logic err, tmo;
        logic [DATA_W-1:0] rd;
        ready_en = 1'b0; slv_mode = 0;
        issue(1'b0, 8'h10, 32'h0);
        pen_n = 0; pulses = 0; err = 1'b0; tmo = 1'b0; rd = 32'hFFFF_FFFF;
        for (int k = 1; k <= 10; k++) begin
            @(posedge _PCLK); #1;
            if (_PENABLE) pen_n++;
            if (rsp_valid) begin pulses++; err = rsp_err; tmo = rsp_timeout; rd = rsp_rdata; end
        end
        n_cmp++; if (pen_n !== 4) begin n_bad++; $display("FAIL to_access_cycles: got %0d want 4", pen_n); end
        n_cmp++; if (pulses !== 1 || err !== 1'b1 || tmo !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL to_rsp: got pulses %0d err %b tmo %b data %h want 1 1 1 0", pulses, err, tmo, rd); end
        n_cmp++; if (_PSEL1 !== 1'b0 || _PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL to_bus_idle: got sel %b en %b rdy %b want 0 0 1", _PSEL1, _PENABLE, cmd_ready); end
        ready_en = 1'b1;
    endtask

    task automatic test_reset_in_access;
        int pulses;
        ready_en = 1'b0;
        issue(1'b1, 8'h30, 32'hCAFE_0001);
        @(posedge _PCLK); #1;
        n_cmp++; if (_PENABLE !== 1'b1) begin n_bad++; $display("FAIL rst_in_access: got en %b want 1", _PENABLE); end
        #2 _PRESETn = 1'b0;
        #1;
        n_cmp++; if ({_PSEL1, _PENABLE, _PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0 || _PADDR !== '0 || _PWDATA !== '0 || rsp_rdata !== '0) begin
            n_bad++; $display("FAIL rst_async_clear: got ctl %b addr %h wdata %h rdata %h want all 0", {_PSEL1, _PENABLE, _PWRITE, rsp_valid, rsp_err, rsp_timeout}, _PADDR, _PWDATA, rsp_rdata);
        end
        pulses = 0;
        repeat (2) begin @(posedge _PCLK); #1; if (rsp_valid) pulses++; end
        ready_en = 1'b1;
        _PRESETn = 1'b1;
        repeat (4) begin @(posedge _PCLK); #1; if (rsp_valid) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_no_rsp: got %0d pulses want 0", pulses); end
        n_cmp++; if (cmd_ready !== 1'b1 || _PSEL1 !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got rdy %b sel %b want 1 0", cmd_ready, _PSEL1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_slverr();
        test_timeout();
        test_reset_in_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
